// File: rtl/lsu_dccm_scrub_pkg.sv
// Shared types and widths for the DCCM single-bit-error scrub buffer.
package lsu_dccm_scrub_pkg;

    localparam int unsigned DCCM_ADDR_W = 16;
    localparam int unsigned DCCM_DATA_W = 39;

    localparam int unsigned STAT_W = 16;

    // One queued write-back: corrected word and where it goes.
    typedef struct packed {
        logic                   valid;
        logic [DCCM_ADDR_W-1:0] addr;
        logic [DCCM_DATA_W-1:0] data;
    } dccm_scrub_entry_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/lsu_dccm_scrub_cam.sv
// Parallel address compare of all queue entries against the capture and LSU write addresses.
module lsu_dccm_scrub_cam #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0]            sec_addr,
    input  logic [ADDR_W-1:0]            lsu_addr,
    output logic [DEPTH-1:0]             sec_hit_c,
    output logic [DEPTH-1:0]             lsu_hit_c
);

    // Valid-qualified equality per entry; duplicates are never allocated so hits are one-hot.
    always_comb begin
        sec_hit_c = '0;
        lsu_hit_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sec_hit_c[i] = valid[i] && (addr[i] == sec_addr);
            lsu_hit_c[i] = valid[i] && (addr[i] == lsu_addr);
        end
    end

endmodule

// File: rtl/lsu_dccm_scrub.sv
// DCCM single-bit-error write-back buffer and final DCCM write-port mux (LSU has priority).
// Optional statistics counters are enabled by defining RV_DCCM_SCRUB_STATS_EN.
module lsu_dccm_scrub
    import lsu_dccm_scrub_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DCCM_ADDR_W,
    parameter int unsigned DATA_W = DCCM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              lsu_freeze_dc3,
    input  logic              dec_tlu_core_ecc_disable,
    input  logic              sec_valid,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [DATA_W-1:0] sec_data,
    input  logic              lsu_dccm_wren,
    input  logic              lsu_dccm_rden,
    input  logic [ADDR_W-1:0] lsu_dccm_wr_addr,
    input  logic [DATA_W-1:0] lsu_dccm_wr_data,
    output logic              dccm_wren,
    output logic [ADDR_W-1:0] dccm_wr_addr,
    output logic [DATA_W-1:0] dccm_wr_data,
    output logic              scrub_pending,
`ifdef RV_DCCM_SCRUB_STATS_EN
    output logic [15:0]       scrub_wr_cnt,
    output logic [15:0]       scrub_drop_cnt,
`endif
    output logic              scrub_overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    // Entry storage is typed from the package, so the widths must agree.
    if (ADDR_W != DCCM_ADDR_W || DATA_W != DCCM_DATA_W || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("lsu_dccm_scrub: unsupported DEPTH/ADDR_W/DATA_W");
    end

    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    dccm_scrub_entry_t            q [DEPTH];
    dccm_scrub_entry_t            head;
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][ADDR_W-1:0] addrs;
    logic [DEPTH-1:0]             sec_hit;
    logic [DEPTH-1:0]             lsu_hit;
    logic empty, full, idle, issue, pop;
    logic cap_try, cap_live, cap_merge, cap_drop, cap_alloc;

    // Flatten entry fields for the compare array.
    always_comb begin
        vld   = '0;
        addrs = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            vld[i]   = q[i].valid;
            addrs[i] = q[i].addr;
        end
    end

    lsu_dccm_scrub_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_cam (
        .valid     (vld),
        .addr      (addrs),
        .sec_addr  (sec_addr),
        .lsu_addr  (lsu_dccm_wr_addr),
        .sec_hit_c (sec_hit),
        .lsu_hit_c (lsu_hit)
    );

    // Queue status, issue/pop and capture decisions; full is taken before any pop.
    always_comb begin
        head      = q[rd_ptr[IDX_W-1:0]];
        empty     = (rd_ptr == wr_ptr);
        full      = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);
        idle      = !(lsu_dccm_wren || lsu_dccm_rden || lsu_freeze_dc3);
        issue     = idle && head.valid;
        pop       = !empty && (issue || !head.valid);
        cap_try   = sec_valid && !dec_tlu_core_ecc_disable;
        cap_live  = cap_try && !(lsu_dccm_wren && (lsu_dccm_wr_addr == sec_addr));
        cap_merge = cap_live && (|sec_hit);
        cap_drop  = cap_live && !(|sec_hit) && full;
        cap_alloc = cap_live && !(|sec_hit) && !full;
    end

    // Write-port mux: LSU first, otherwise the queue head on idle cycles.
    always_comb begin
        dccm_wren    = issue;
        dccm_wr_addr = head.addr;
        dccm_wr_data = head.data;
        if (lsu_dccm_wren) begin
            dccm_wren    = 1'b1;
            dccm_wr_addr = lsu_dccm_wr_addr;
            dccm_wr_data = lsu_dccm_wr_data;
        end
    end

    assign scrub_pending = |vld;

    // Entry storage: LSU hazard invalidate, in-place merge, pop clear, allocation.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (lsu_dccm_wren && lsu_hit[i]) begin
                    q[i].valid <= 1'b0;
                end
                if (cap_merge && sec_hit[i]) begin
                    q[i].data <= sec_data;
                end
                if (pop && (IDX_W'(i) == rd_ptr[IDX_W-1:0])) begin
                    q[i].valid <= 1'b0;
                end
                if (cap_alloc && (IDX_W'(i) == wr_ptr[IDX_W-1:0])) begin
                    q[i] <= '{valid: 1'b1, addr: sec_addr, data: sec_data};
                end
            end
        end
    end

    // Pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            scrub_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cap_alloc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (cap_drop) begin
                scrub_overflow <= 1'b1;
            end
        end
    end

`ifdef RV_DCCM_SCRUB_STATS_EN
    // Saturating counts of issued scrub writes and captures dropped on full.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            scrub_wr_cnt   <= '0;
            scrub_drop_cnt <= '0;
        end else begin
            if (issue) begin
                scrub_wr_cnt <= sat_inc(scrub_wr_cnt);
            end
            if (cap_drop) begin
                scrub_drop_cnt <= sat_inc(scrub_drop_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dccm_scrub.sv
// Directed self-checking bench for lsu_dccm_scrub (DEPTH = 4).
module tb_lsu_dccm_scrub;
    import lsu_dccm_scrub_pkg::*;

    localparam int unsigned AW = DCCM_ADDR_W;
    localparam int unsigned DW = DCCM_DATA_W;

    logic          clk;
    logic          rst_l;
    logic          lsu_freeze_dc3;
    logic          dec_tlu_core_ecc_disable;
    logic          sec_valid;
    logic [AW-1:0] sec_addr;
    logic [DW-1:0] sec_data;
    logic          lsu_dccm_wren;
    logic          lsu_dccm_rden;
    logic [AW-1:0] lsu_dccm_wr_addr;
    logic [DW-1:0] lsu_dccm_wr_data;
    logic          dccm_wren;
    logic [AW-1:0] dccm_wr_addr;
    logic [DW-1:0] dccm_wr_data;
    logic          scrub_pending;
    logic          scrub_overflow;
`ifdef RV_DCCM_SCRUB_STATS_EN
    logic [15:0]   scrub_wr_cnt;
    logic [15:0]   scrub_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    lsu_dccm_scrub #(.DEPTH(4)) dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .lsu_freeze_dc3           (lsu_freeze_dc3),
        .dec_tlu_core_ecc_disable (dec_tlu_core_ecc_disable),
        .sec_valid                (sec_valid),
        .sec_addr                 (sec_addr),
        .sec_data                 (sec_data),
        .lsu_dccm_wren            (lsu_dccm_wren),
        .lsu_dccm_rden            (lsu_dccm_rden),
        .lsu_dccm_wr_addr         (lsu_dccm_wr_addr),
        .lsu_dccm_wr_data         (lsu_dccm_wr_data),
        .dccm_wren                (dccm_wren),
        .dccm_wr_addr             (dccm_wr_addr),
        .dccm_wr_data             (dccm_wr_data),
        .scrub_pending            (scrub_pending),
`ifdef RV_DCCM_SCRUB_STATS_EN
        .scrub_wr_cnt             (scrub_wr_cnt),
        .scrub_drop_cnt           (scrub_drop_cnt),
`endif
        .scrub_overflow           (scrub_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        lsu_freeze_dc3           = 1'b0;
        dec_tlu_core_ecc_disable = 1'b0;
        sec_valid                = 1'b0;
        sec_addr                 = '0;
        sec_data                 = '0;
        lsu_dccm_wren            = 1'b0;
        lsu_dccm_rden            = 1'b0;
        lsu_dccm_wr_addr         = '0;
        lsu_dccm_wr_data         = '0;
    endtask

    task automatic capture(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sec_valid = 1'b1;
        sec_addr  = a;
        sec_data  = d;
    endtask

    initial begin
        quiet();
        rst_l = 1'b0;
        #3;
        // Reset state
        chk("rst_wren", 64'(dccm_wren), 64'(0));
        chk("rst_addr", 64'(dccm_wr_addr), 64'(0));
        chk("rst_data", 64'(dccm_wr_data), 64'(0));
        chk("rst_pending", 64'(scrub_pending), 64'(0));
        chk("rst_ovf", 64'(scrub_overflow), 64'(0));
        tick();
        tick();
        rst_l = 1'b1;
        tick();

        // Single capture on an idle port
        capture(16'h0040, 39'h12_3456_789A);
        #1 chk("t1_wren_empty", 64'(dccm_wren), 64'(0));
        tick();
        quiet();
        #1;
        chk("t1_wren", 64'(dccm_wren), 64'(1));
        chk("t1_addr", 64'(dccm_wr_addr), 64'(16'h0040));
        chk("t1_data", 64'(dccm_wr_data), 64'(39'h12_3456_789A));
        chk("t1_pending", 64'(scrub_pending), 64'(1));
        tick();
        #1;
        chk("t1_pending_clr", 64'(scrub_pending), 64'(0));
        chk("t1_wren_clr", 64'(dccm_wren), 64'(0));

        // LSU read activity blocks the scrub write
        tick();
        capture(16'h0100, 39'h0A_BCDE_F012);
        tick();
        quiet();
        for (int i = 0; i < 5; i++) begin
            lsu_dccm_rden = 1'b1;
            #1 chk("t2_blocked", 64'(dccm_wren), 64'(0));
            tick();
        end
        quiet();
        #1;
        chk("t2_wren", 64'(dccm_wren), 64'(1));
        chk("t2_addr", 64'(dccm_wr_addr), 64'(16'h0100));
        chk("t2_data", 64'(dccm_wr_data), 64'(39'h0A_BCDE_F012));
        tick();
        #1 chk("t2_pending", 64'(scrub_pending), 64'(0));

        // LSU write hazard invalidates the queued entry
        tick();
        lsu_freeze_dc3 = 1'b1;
        capture(16'h0200, 39'h33_3333_3333);
        tick();
        quiet();
        lsu_freeze_dc3   = 1'b1;
        lsu_dccm_wren    = 1'b1;
        lsu_dccm_wr_addr = 16'h0200;
        lsu_dccm_wr_data = 39'h7F_0000_0001;
        #1;
        chk("t3_lsu_wren", 64'(dccm_wren), 64'(1));
        chk("t3_lsu_data", 64'(dccm_wr_data), 64'(39'h7F_0000_0001));
        chk("t3_pending_pre", 64'(scrub_pending), 64'(1));
        tick();
        quiet();
        lsu_freeze_dc3 = 1'b1;
        #1;
        chk("t3_pending_inv", 64'(scrub_pending), 64'(0));
        chk("t3_wren_frz", 64'(dccm_wren), 64'(0));
        tick();
        quiet();
        #1 chk("t3_no_write", 64'(dccm_wren), 64'(0));
        tick();

        // Duplicate captures merge into one entry
        lsu_freeze_dc3 = 1'b1;
        capture(16'h0300, 39'h11_1111_1111);
        tick();
        capture(16'h0300, 39'h22_2222_2222);
        tick();
        quiet();
        #1;
        chk("t4_wren", 64'(dccm_wren), 64'(1));
        chk("t4_addr", 64'(dccm_wr_addr), 64'(16'h0300));
        chk("t4_data", 64'(dccm_wr_data), 64'(39'h22_2222_2222));
        tick();
        #1;
        chk("t4_single", 64'(dccm_wren), 64'(0));
        chk("t4_pending", 64'(scrub_pending), 64'(0));

        // Capture suppressed by a same-address LSU write; capture blocked by ECC disable
        tick();
        capture(16'h0500, 39'h55_5555_5555);
        lsu_dccm_wren    = 1'b1;
        lsu_dccm_wr_addr = 16'h0500;
        lsu_dccm_wr_data = 39'h01_0203_0405;
        #1 chk("t5_lsu_addr", 64'(dccm_wr_addr), 64'(16'h0500));
        tick();
        quiet();
        #1 chk("t5_suppressed", 64'(scrub_pending), 64'(0));
        tick();
        capture(16'h0504, 39'h44_4444_4444);
        dec_tlu_core_ecc_disable = 1'b1;
        tick();
        quiet();
        #1 chk("t5_ecc_disable", 64'(scrub_pending), 64'(0));
        tick();

        // Overflow: fifth distinct capture is dropped, then four ordered writes
        for (int i = 0; i < 5; i++) begin
            lsu_freeze_dc3 = 1'b1;
            capture(AW'(16'h0400 + 4 * i), DW'(39'h40_0000_0000 + i));
            if (i == 4) begin
                #1 chk("t6_ovf_pre", 64'(scrub_overflow), 64'(0));
            end
            tick();
        end
        quiet();
        #1;
        chk("t6_ovf", 64'(scrub_overflow), 64'(1));
`ifdef RV_DCCM_SCRUB_STATS_EN
        chk("t6_drop_cnt", 64'(scrub_drop_cnt), 64'(1));
`endif
        for (int j = 0; j < 4; j++) begin
            chk("t6_wren", 64'(dccm_wren), 64'(1));
            chk("t6_addr", 64'(dccm_wr_addr), 64'(16'h0400 + 4 * j));
            chk("t6_data", 64'(dccm_wr_data), 64'(39'h40_0000_0000 + j));
            tick();
            #1;
        end
        chk("t6_drained", 64'(dccm_wren), 64'(0));
        chk("t6_pending", 64'(scrub_pending), 64'(0));
        chk("t6_ovf_sticky", 64'(scrub_overflow), 64'(1));
`ifdef RV_DCCM_SCRUB_STATS_EN
        chk("t6_wr_cnt", 64'(scrub_wr_cnt), 64'(7));
`endif

        // Reset in the middle of a drain discards the remaining entries
        tick();
        for (int i = 0; i < 4; i++) begin
            lsu_freeze_dc3 = 1'b1;
            capture(AW'(16'h0600 + 4 * i), DW'(39'h60_0000_0000 + i));
            tick();
        end
        quiet();
        for (int j = 0; j < 2; j++) begin
            #1;
            chk("t7_wren", 64'(dccm_wren), 64'(1));
            chk("t7_addr", 64'(dccm_wr_addr), 64'(16'h0600 + 4 * j));
            tick();
        end
        rst_l = 1'b0;
        #1;
        chk("t7_rst_wren", 64'(dccm_wren), 64'(0));
        chk("t7_rst_addr", 64'(dccm_wr_addr), 64'(0));
        chk("t7_rst_data", 64'(dccm_wr_data), 64'(0));
        chk("t7_rst_pending", 64'(scrub_pending), 64'(0));
        chk("t7_rst_ovf", 64'(scrub_overflow), 64'(0));
`ifdef RV_DCCM_SCRUB_STATS_EN
        chk("t7_rst_wr_cnt", 64'(scrub_wr_cnt), 64'(0));
        chk("t7_rst_drop_cnt", 64'(scrub_drop_cnt), 64'(0));
`endif
        tick();
        tick();
        rst_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1 chk("t7_after_rst", 64'(dccm_wren), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dccm_scrub.md
# lsu_dccm_scrub

DCCM single-bit-error write-back buffer, placed directly upstream of the DCCM write port of the memory wrapper. It captures corrected DCCM read data reported by the LSU ECC logic and queues it. It writes the data back into the DCCM on idle port cycles so that correctable errors do not accumulate into uncorrectable ones. It also owns the final DCCM write-port mux, with the LSU always given priority.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, at least 2
- ADDR_W, `RV_DCCM_BITS, DCCM byte address width
- DATA_W, `RV_DCCM_FDATA_WIDTH, data width including ECC (39)

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- lsu_freeze_dc3  in  1  blocks scrub issue while high
- dec_tlu_core_ecc_disable  in  1  while high, no new entries are captured
- sec_valid  in  1  single-bit error corrected this cycle
- sec_addr  in  ADDR_W  address of the corrected word
- sec_data  in  DATA_W  corrected data with regenerated ECC
- lsu_dccm_wren  in  1  LSU write request
- lsu_dccm_rden  in  1  LSU read request
- lsu_dccm_wr_addr  in  ADDR_W  LSU write address
- lsu_dccm_wr_data  in  DATA_W  LSU write data
- dccm_wren  out  1  write enable to the DCCM
- dccm_wr_addr  out  ADDR_W  write address to the DCCM
- dccm_wr_data  out  DATA_W  write data to the DCCM
- scrub_pending  out  1  at least one valid entry is queued
- scrub_overflow  out  1  sticky; a capture was dropped because the queue was full

## Operation
- Circular FIFO with DEPTH entries. Each entry holds {valid, addr, data}.
  - rd_ptr and wr_ptr are each log2(DEPTH)+1 bits, with the top bit used as the wrap bit.
  - empty = pointers equal. full = index bits equal and wrap bits differ.
- Port is idle when all of the following are 0: lsu_dccm_wren, lsu_dccm_rden, lsu_freeze_dc3.
- Write-port mux:
  - If lsu_dccm_wren = 1, the outputs follow the lsu_dccm_wr_* inputs.
  - Otherwise, if the port is idle and the head entry is valid, the outputs carry the head entry's addr/data with dccm_wren = 1.
  - Otherwise dccm_wren = 0, and addr/data hold the head entry's values.
- Capture is attempted when sec_valid = 1 and dec_tlu_core_ecc_disable = 0:
  - If lsu_dccm_wren = 1 and lsu_dccm_wr_addr equals sec_addr: capture is suppressed (the LSU data is newer).
  - Else if a valid queued entry has the same addr: that entry's data is overwritten in place, with no new entry allocated.
  - Else if the queue is full: the capture is dropped and scrub_overflow is set.
  - Else: a new entry is written at wr_ptr with valid = 1.
- Full is evaluated on the pre-pop state. A capture arriving in the same cycle as a pop from a full queue is dropped.
- Hazard: an LSU write whose address matches any valid entry clears that entry's valid bit in the same cycle.
- Pop rules:
  - A valid head is popped in the same cycle it is issued.
  - An invalid head that is not empty is popped without a write, one entry per cycle, regardless of port idle state.
- scrub_pending = OR of the valid bits of all entries between rd_ptr and wr_ptr.

## Timing
- Reset values:
  - dccm_wren = 0, dccm_wr_addr = 0, dccm_wr_data = 0.
  - scrub_pending = 0, scrub_overflow = 0.
  - Pointers 0; all valid bits 0.
- Mux outputs are combinational from the LSU inputs and the registered queue head. There are no combinational paths from sec_* to the outputs.
- Latency: a capture at clock edge N can be written to the DCCM in cycle N+1 at the earliest, provided the port is idle.
- Throughput: one scrub write per idle cycle.
- scrub_overflow stays set until rst_l is asserted.
- Reset asserted mid-operation discards all entries immediately; nothing is written back.

## Configuration
- Macro RV_DCCM_SCRUB_STATS_EN.
  - When defined, adds outputs scrub_wr_cnt[15:0] and scrub_drop_cnt[15:0].
  - scrub_wr_cnt increments on each issued scrub write; scrub_drop_cnt increments on each capture dropped because the queue was full.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the counters and their ports do not exist. All other behaviour is identical.

## Structure
- The entry struct dccm_scrub_entry_t {valid, addr, data} goes in veer_types.
- Sub-module lsu_dccm_scrub_cam: a parallel address compare across all entries.
  - Returns a one-hot match vector for sec_addr and another for lsu_dccm_wr_addr, both qualified by the entry valid bits.
- Top level holds the pointers, the FIFO storage, the write-port mux and the optional counters.

## Test plan
- Single capture: sec_valid with addr 0x0040, data 0x12_3456_789A; port idle -> the next cycle shows dccm_wren = 1, addr 0x0040, that data; scrub_pending then returns to 0.
- LSU priority: capture addr 0x0100, then hold lsu_dccm_rden = 1 for 5 cycles -> no scrub write during those cycles; the scrub write occurs in the first idle cycle after.
- Hazard: capture addr 0x0200, then an LSU write to 0x0200 while freeze = 1 -> the entry is invalidated and popped silently; no scrub write to 0x0200 ever occurs.
- Duplicate: two captures to addr 0x0300 with data A then B while frozen -> one entry exists; on unfreeze, a single write of B.
- Overflow (DEPTH = 4): 5 distinct captures while frozen -> the 5th is dropped, scrub_overflow = 1, scrub_drop_cnt = 1 (when STATS is enabled); unfreeze -> 4 writes in order.
- Reset mid-drain: assert rst_l low after 2 of 4 writes -> all outputs are 0 immediately; after release, no further writes occur.
